// File: rtl/instruction_fetch.sv
// Instruction fetch stage: sequential PC generator feeding a small FIFO toward decode.
// Optional FETCH_ALIGN_CHECK_EN adds a sticky misaligned-redirect fault output.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic        fetch_fault
`endif
);

    localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = AW + 1;

    // Handshake: an entry transfers to decode in any cycle where out_valid and
    // out_ready are both high and no redirect is present; the head entry is held
    // unchanged while out_valid is high and out_ready is low.

    logic [31:0]   fetch_pc;
    logic [31:0]   pc_buf    [BUF_DEPTH];
    logic [31:0]   instr_buf [BUF_DEPTH];
    logic [CW-1:0] head;
    logic [CW-1:0] tail;
    logic [CW-1:0] count;
    logic          full;
    logic          push;
    logic          pop;
    logic          inhibit;
    logic [31:0]   redirect_target;

    function automatic logic [CW-1:0] ptr_inc(input logic [CW-1:0] p);
        return (p == CW'(BUF_DEPTH - 1)) ? '0 : p + CW'(1);
    endfunction

    assign redirect_target = redirect_pc & ~32'h0000_0003;

`ifdef FETCH_ALIGN_CHECK_EN
    logic fault_q;
    logic misaligned;

    assign misaligned  = |redirect_pc[1:0];
    assign inhibit     = fault_q;
    assign fetch_fault = fault_q;

    // Sticky until reset; later aligned redirects leave it set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else if (redirect_valid && misaligned) begin
            fault_q <= 1'b1;
        end
    end
`else
    assign inhibit = 1'b0;
`endif

    assign imem_pc   = fetch_pc;
    assign full      = (count == CW'(BUF_DEPTH));
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready && !redirect_valid;
    assign push      = !redirect_valid && !inhibit && (!full || pop);
    assign out_pc    = out_valid ? pc_buf[head[AW-1:0]]    : '0;
    assign out_instr = out_valid ? instr_buf[head[AW-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_target;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                fetch_pc <= fetch_pc + 32'd4;
                tail     <= ptr_inc(tail);
            end
            if (pop) begin
                head <= ptr_inc(head);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Storage needs no reset: entries are only visible while count is nonzero.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_buf[tail[AW-1:0]]    <= fetch_pc;
            instr_buf[tail[AW-1:0]] <= imem_instr;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch (RESET_PC=32'h100, BUF_DEPTH=2);
// covers the FETCH_ALIGN_CHECK_EN build when that macro is defined.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        fetch_fault;
`endif

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    instruction_fetch #(.RESET_PC(32'h0000_0100), .BUF_DEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_pc        (imem_pc),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .fetch_fault    (fetch_fault)
`endif
    );

    // Instruction memory contents: word index scrambled with a fixed pattern.
    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        return {2'b00, pc[31:2]} ^ 32'h5A5A_0000;
    endfunction

    assign imem_instr = mem_word(imem_pc);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_stream(input logic [31:0] pc);
        exp_q.delete();
        for (int i = 0; i < 64; i++) begin
            exp_q.push_back(pc + 32'(4 * i));
        end
    endtask

    // Monitor: every accepted transfer must match the next expected fetch.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid && out_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got pc %h expected no transfer", out_pc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("sb_pc", out_pc, e);
                check("sb_instr", out_instr, mem_word(e));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        repeat (3) tick();

        @(negedge clk);
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_out_pc", out_pc, 32'h0);
        check("reset_out_instr", out_instr, 32'h0);
        check("reset_imem_pc", imem_pc, 32'h100);
`ifdef FETCH_ALIGN_CHECK_EN
        check("reset_fault", 32'(fetch_fault), 32'd0);
`endif

        // Reset release with decode always ready.
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        start_stream(32'h100);
        @(negedge clk);
        check("first_imem_pc", imem_pc, 32'h100);
        check("first_valid", 32'(out_valid), 32'd0);
        tick();
        @(negedge clk);
        check("stream_valid", 32'(out_valid), 32'd1);
        check("stream_pc0", out_pc, 32'h100);
        tick();
        @(negedge clk);
        check("stream_pc1", out_pc, 32'h104);

        // Backpressure: head 0x108 must hold, fetch freezes at head+8.
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_pc", out_pc, 32'h108);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            tick();
        end
        @(negedge clk);
        check("bp_imem_frozen", imem_pc, 32'h110);
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_drain0", out_pc, 32'h108);
        tick();
        @(negedge clk);
        check("bp_drain1", out_pc, 32'h10C);
        tick();
        @(negedge clk);
        check("bp_drain2", out_pc, 32'h110);

        // Redirect while the buffer is full.
        tick();
        out_ready = 1'b0;
        repeat (3) tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        start_stream(32'h40);
        tick();
        redirect_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("rd_gap_valid", 32'(out_valid), 32'd0);
        tick();
        @(negedge clk);
        check("rd_target_pc", out_pc, 32'h40);
        check("rd_target_instr", out_instr, 32'h5A5A_0010);
        tick();
        tick();

        // Redirect coinciding with out_ready: head is dropped, not consumed.
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h80;
        start_stream(32'h80);
        @(negedge clk);
        check("rp_head_valid", 32'(out_valid), 32'd1);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("rp_gap_valid", 32'(out_valid), 32'd0);
        tick();
        @(negedge clk);
        check("rp_target_pc", out_pc, 32'h80);
        tick();

        // PC wrap at the top of the address space.
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        start_stream(32'hFFFF_FFFC);
        tick();
        redirect_valid = 1'b0;
        tick();
        @(negedge clk);
        check("wrap_pc0", out_pc, 32'hFFFF_FFFC);
        tick();
        @(negedge clk);
        check("wrap_pc1", out_pc, 32'h0000_0000);
        tick();
        @(negedge clk);
        check("wrap_pc2", out_pc, 32'h0000_0004);

        // Misaligned redirect.
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h42;
`ifdef FETCH_ALIGN_CHECK_EN
        exp_q.delete();
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("al_fault_set", 32'(fetch_fault), 32'd1);
        check("al_valid_low", 32'(out_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            check("al_valid_stays_low", 32'(out_valid), 32'd0);
        end
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        tick();
        redirect_valid = 1'b0;
        tick();
        @(negedge clk);
        check("al_fault_sticky", 32'(fetch_fault), 32'd1);
        check("al_sticky_valid", 32'(out_valid), 32'd0);
        tick();
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        check("al_fault_cleared", 32'(fetch_fault), 32'd0);
        tick();
        rst_n = 1'b1;
        start_stream(32'h100);
        tick();
        @(negedge clk);
        check("al_restart_pc", out_pc, 32'h100);
`else
        start_stream(32'h40);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("al_gap_valid", 32'(out_valid), 32'd0);
        tick();
        @(negedge clk);
        check("al_forced_pc", out_pc, 32'h40);
`endif

        tick();
        tick();
        out_ready = 1'b0;
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
